// File: rtl/pomodoro_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pomodoro_pkg                                                 |
// | Description : Shared encodings for the Pomodoro session scheduler: phase   |
// |               codes, sequencer state type and the phase length lookup.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package pomodoro_pkg;

  // Phase codes as presented on the phase output
  localparam logic [1:0] PH_WORK  = 2'd0;
  localparam logic [1:0] PH_SHORT = 2'd1;
  localparam logic [1:0] PH_LONG  = 2'd2;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALERT = 2'd3
  } state_t;

  // Length in seconds of a phase; lengths are passed in because they are
  // parameters of the instantiating block. Caller truncates to its TIME_W.
  function automatic int phase_len(input logic [1:0] ph,
                                   input int         work_s,
                                   input int         short_s,
                                   input int         long_s);
    case (ph)
      PH_SHORT: return short_s;
      PH_LONG:  return long_s;
      default:  return work_s;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pomo_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pomo_tick_gen                                                |
// | Description : One-second prescaler. Counts 0..CLK_HZ-1 while enabled and   |
// |               flags the last count as a tick; holds its count while        |
// |               disabled; i_clr forces the count back to zero.               |
// | Ports       : clk, rst_n (async active-low), i_en, i_clr, o_tick           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pomo_tick_gen #(
  parameter int CLK_HZ = 125000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              CNT_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pomodoro_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pomodoro_sequencer                                           |
// | Description : Pomodoro session scheduler. Runs the one-second countdown,   |
// |               sequences WORK -> SHORT_BREAK with a LONG_BREAK after every  |
// |               LONG_EVERY work sessions, decodes start/skip/clear buttons   |
// |               and raises the buzzer while a finished phase is alerting.    |
// | Ports       : clk, rst_n (async active-low)                                |
// |               btn_start/btn_skip/btn_clear : debounced levels, rising edge |
// |               phase, running, remain_s, total_s, sess_cnt : status         |
// |               phase_done : 1-cycle pulse on phase end or skip in RUN       |
// |               buzzer     : high throughout ALERT                           |
// | Options     : `define POMO_AUTO_ADVANCE_EN -> ALERT leaves by itself after |
// |               ALERT_S seconds; otherwise ALERT waits for start.            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pomodoro_sequencer
  import pomodoro_pkg::*;
#(
  parameter int CLK_HZ     = 125000000,
  parameter int WORK_S     = 1500,
  parameter int SHORT_S    = 300,
  parameter int LONG_S     = 900,
  parameter int LONG_EVERY = 4,
  parameter int ALERT_S    = 3,
  parameter int TIME_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_skip,
  input  logic              btn_clear,
  output logic [1:0]        phase,
  output logic              running,
  output logic [TIME_W-1:0] remain_s,
  output logic [TIME_W-1:0] total_s,
  output logic [2:0]        sess_cnt,
  output logic              phase_done,
  output logic              buzzer
);

  localparam logic [TIME_W-1:0] c_work_len   = TIME_W'(WORK_S);
  localparam logic [TIME_W-1:0] c_alert_max  = TIME_W'(ALERT_S);
  localparam logic [2:0]        c_long_every = 3'(LONG_EVERY);

  state_t            r_state;
  logic [TIME_W-1:0] r_alert_cnt;

  // Button edge detection: previous level plus a registered rise flag, so an
  // action lands one cycle after the sampling edge.
  logic r_start_prev, r_skip_prev, r_clear_prev;
  logic r_start_ev,   r_skip_ev,   r_clear_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_prev <= 1'b0;
      r_skip_prev  <= 1'b0;
      r_clear_prev <= 1'b0;
      r_start_ev   <= 1'b0;
      r_skip_ev    <= 1'b0;
      r_clear_ev   <= 1'b0;
    end else begin
      r_start_prev <= btn_start;
      r_skip_prev  <= btn_skip;
      r_clear_prev <= btn_clear;
      r_start_ev   <= btn_start & ~r_start_prev;
      r_skip_ev    <= btn_skip  & ~r_skip_prev;
      r_clear_ev   <= btn_clear & ~r_clear_prev;
    end
  end

  // clear > skip > start
  logic w_act_clear, w_act_skip, w_act_start;
  assign w_act_clear = r_clear_ev;
  assign w_act_skip  = r_skip_ev  & ~r_clear_ev;
  assign w_act_start = r_start_ev & ~r_skip_ev & ~r_clear_ev;

  // Next phase, session count and length if the current phase is advanced
  logic [2:0]        w_sess_inc;
  logic [1:0]        w_adv_phase;
  logic [2:0]        w_adv_sess;
  logic [TIME_W-1:0] w_adv_len;

  always_comb begin
    w_sess_inc  = sess_cnt + 3'd1;
    w_adv_phase = PH_WORK;
    w_adv_sess  = sess_cnt;
    if (phase == PH_WORK) begin
      if (w_sess_inc == c_long_every) begin
        w_adv_sess  = 3'd0;
        w_adv_phase = PH_LONG;
      end else begin
        w_adv_sess  = w_sess_inc;
        w_adv_phase = PH_SHORT;
      end
    end
    w_adv_len = TIME_W'(phase_len(w_adv_phase, WORK_S, SHORT_S, LONG_S));
  end

  // One-second prescaler
  logic w_tick, w_tick_en, w_presc_clr, w_auto_exit;

  assign w_tick_en = (r_state == ST_RUN) || (r_state == ST_ALERT);

`ifdef POMO_AUTO_ADVANCE_EN
  localparam logic [TIME_W-1:0] c_alert_last = TIME_W'(ALERT_S - 1);
  assign w_auto_exit = (r_state == ST_ALERT) && w_tick && (r_alert_cnt == c_alert_last);
`else
  assign w_auto_exit = 1'b0;
`endif

  // Zero the prescaler on clear, IDLE->RUN and every phase change so each
  // phase starts on a whole second; pause/resume does not zero it.
  assign w_presc_clr = w_act_clear
                     | ((r_state == ST_IDLE)  && (w_act_skip | w_act_start))
                     | ((r_state == ST_RUN)   && w_act_skip)
                     | ((r_state == ST_PAUSE) && w_act_skip)
                     | ((r_state == ST_ALERT) && (w_act_start | w_auto_exit));

  pomo_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_tick_en),
    .i_clr  (w_presc_clr),
    .o_tick (w_tick)
  );

  // Sequencer with registered outputs. Within RUN a button action takes the
  // cycle and a coincident tick is dropped. skip is not acted on in ALERT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      phase       <= PH_WORK;
      remain_s    <= c_work_len;
      total_s     <= c_work_len;
      sess_cnt    <= 3'd0;
      running     <= 1'b0;
      phase_done  <= 1'b0;
      buzzer      <= 1'b0;
      r_alert_cnt <= '0;
    end else begin
      phase_done <= 1'b0;
      if (w_act_clear) begin
        r_state     <= ST_IDLE;
        phase       <= PH_WORK;
        remain_s    <= c_work_len;
        total_s     <= c_work_len;
        sess_cnt    <= 3'd0;
        running     <= 1'b0;
        buzzer      <= 1'b0;
        r_alert_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_act_skip) begin
              phase    <= w_adv_phase;
              sess_cnt <= w_adv_sess;
              total_s  <= w_adv_len;
              remain_s <= w_adv_len;
            end else if (w_act_start) begin
              r_state <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (w_act_skip) begin
              phase_done <= 1'b1;
              phase      <= w_adv_phase;
              sess_cnt   <= w_adv_sess;
              total_s    <= w_adv_len;
              remain_s   <= w_adv_len;
            end else if (w_act_start) begin
              r_state <= ST_PAUSE;
              running <= 1'b0;
            end else if (w_tick && (remain_s != '0)) begin
              remain_s <= remain_s - TIME_W'(1);
              if (remain_s == TIME_W'(1)) begin
                phase_done  <= 1'b1;
                r_state     <= ST_ALERT;
                running     <= 1'b0;
                buzzer      <= 1'b1;
                r_alert_cnt <= '0;
              end
            end
          end
          ST_PAUSE: begin
            if (w_act_skip) begin
              r_state  <= ST_IDLE;
              phase    <= w_adv_phase;
              sess_cnt <= w_adv_sess;
              total_s  <= w_adv_len;
              remain_s <= w_adv_len;
            end else if (w_act_start) begin
              r_state <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_ALERT: begin
            if (w_act_start || w_auto_exit) begin
              r_state  <= ST_RUN;
              running  <= 1'b1;
              buzzer   <= 1'b0;
              phase    <= w_adv_phase;
              sess_cnt <= w_adv_sess;
              total_s  <= w_adv_len;
              remain_s <= w_adv_len;
            end else if (w_tick && (r_alert_cnt != c_alert_max)) begin
              r_alert_cnt <= r_alert_cnt + TIME_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pomodoro_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pomodoro_sequencer                                        |
// | Description : Self-checking bench for pomodoro_sequencer: directed         |
// |               scenarios plus random button traffic against a reference     |
// |               model of the session rules.                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pomodoro_sequencer;

  localparam int P_CLK   = 10;
  localparam int P_WORK  = 3;
  localparam int P_SHORT = 2;
  localparam int P_LONG  = 4;
  localparam int P_EVERY = 2;
  localparam int P_ALERT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_skip = 1'b0;
  logic        btn_clear = 1'b0;
  logic [1:0]  phase;
  logic        running;
  logic [15:0] remain_s;
  logic [15:0] total_s;
  logic [2:0]  sess_cnt;
  logic        phase_done;
  logic        buzzer;

  int total = 0;
  int bad   = 0;

  pomodoro_sequencer #(
    .CLK_HZ(P_CLK), .WORK_S(P_WORK), .SHORT_S(P_SHORT), .LONG_S(P_LONG),
    .LONG_EVERY(P_EVERY), .ALERT_S(P_ALERT), .TIME_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_skip(btn_skip),
    .btn_clear(btn_clear), .phase(phase), .running(running), .remain_s(remain_s),
    .total_s(total_s), .sess_cnt(sess_cnt), .phase_done(phase_done), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Mode names: 0 idle, 1 counting down, 2 paused, 3 alerting
  int m_mode, m_phase, m_remain, m_total, m_sess, m_sub, m_alert;
  bit m_done;
  bit pend_start, pend_skip, pend_clr, last_start, last_skip, last_clr;
  bit do_clr, do_skip, do_start, m_tick, m_zero, m_en;

  function automatic int len_of(input int ph);
    return (ph == 1) ? P_SHORT : (ph == 2) ? P_LONG : P_WORK;
  endfunction

  task m_advance();
    if (m_phase == 0) begin
      m_sess = m_sess + 1;
      if (m_sess == P_EVERY) begin m_sess = 0; m_phase = 2; end
      else m_phase = 1;
    end else begin
      m_phase = 0;
    end
    m_total  = len_of(m_phase);
    m_remain = m_total;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_phase = 0; m_remain = P_WORK; m_total = P_WORK; m_sess = 0;
      m_sub = 0; m_alert = 0; m_done = 0;
      pend_start = 0; pend_skip = 0; pend_clr = 0;
      last_start = 0; last_skip = 0; last_clr = 0;
    end else begin
      do_clr   = pend_clr;
      do_skip  = pend_skip && !pend_clr;
      do_start = pend_start && !pend_skip && !pend_clr;
      pend_start = btn_start && !last_start;
      pend_skip  = btn_skip  && !last_skip;
      pend_clr   = btn_clear && !last_clr;
      last_start = btn_start; last_skip = btn_skip; last_clr = btn_clear;
      m_en   = (m_mode == 1) || (m_mode == 3);
      m_tick = m_en && (m_sub == P_CLK - 1);
      m_zero = 0;
      m_done = 0;
      if (do_clr) begin
        m_mode = 0; m_phase = 0; m_remain = P_WORK; m_total = P_WORK; m_sess = 0; m_zero = 1;
      end else if (m_mode == 0) begin
        if (do_skip) begin m_advance(); m_zero = 1; end
        else if (do_start) begin m_mode = 1; m_zero = 1; end
      end else if (m_mode == 1) begin
        if (do_skip) begin m_done = 1; m_advance(); m_zero = 1; end
        else if (do_start) m_mode = 2;
        else if (m_tick && m_remain > 0) begin
          m_remain = m_remain - 1;
          if (m_remain == 0) begin m_done = 1; m_mode = 3; m_alert = 0; end
        end
      end else if (m_mode == 2) begin
        if (do_skip) begin m_advance(); m_mode = 0; m_zero = 1; end
        else if (do_start) m_mode = 1;
      end else begin
        if (do_start) begin m_advance(); m_mode = 1; m_zero = 1; end
        else if (m_tick) begin
          m_alert = m_alert + 1;
`ifdef POMO_AUTO_ADVANCE_EN
          if (m_alert >= P_ALERT) begin m_advance(); m_mode = 1; m_zero = 1; end
`endif
        end
      end
      if (m_zero) m_sub = 0;
      else if (m_en) m_sub = (m_sub + 1) % P_CLK;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input bit s, input bit k, input bit c);
    btn_start = s; btn_skip = k; btn_clear = c;
    @(negedge clk);
    btn_start = 0; btn_skip = 0; btn_clear = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; btn_start = 0; btn_skip = 0; btn_clear = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic fresh_run();
    do_reset();
    press(1, 0, 0);
  endtask

  task automatic finish_phase();
    int n;
    n = 0;
    while (buzzer !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (n >= 200) begin bad++; $display("FAIL finish_phase: buzzer never rose within %0d cycles", n); end
`ifdef POMO_AUTO_ADVANCE_EN
    n = 0;
    while (buzzer === 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (n >= 200) begin bad++; $display("FAIL finish_phase: buzzer never fell within %0d cycles", n); end
`else
    press(1, 0, 0);
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({phase, running, remain_s, total_s, sess_cnt, phase_done, buzzer} !==
        {2'd0, 1'b0, 16'd3, 16'd3, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: ph=%0d run=%0d rem=%0d tot=%0d sess=%0d done=%0d buz=%0d want 0 0 3 3 0 0 0",
               phase, running, remain_s, total_s, sess_cnt, phase_done, buzzer);
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_countdown();
    int pulses;
    fresh_run();
    total++;
    if (running !== 1'b1 || remain_s !== 16'd3) begin
      bad++; $display("FAIL start_run: run=%0d rem=%0d want run=1 rem=3", running, remain_s);
    end
    pulses = 0;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (phase_done === 1'b1) pulses++;
      if (c == 9 || (c % 10) == 0) begin
        total++;
        if (remain_s !== 16'(3 - c / 10)) begin
          bad++; $display("FAIL countdown c=%0d: rem=%0d want %0d", c, remain_s, 3 - c / 10);
        end
      end
    end
    total++;
    if (pulses != 1 || buzzer !== 1'b1 || running !== 1'b0) begin
      bad++; $display("FAIL work_end: pulses=%0d buz=%0d run=%0d want 1 1 0", pulses, buzzer, running);
    end
  endtask

  task automatic test_alert();
    int n;
    fresh_run();
    repeat (30) @(negedge clk);
`ifdef POMO_AUTO_ADVANCE_EN
    n = 0;
    while (buzzer === 1'b1 && n < 100) begin n++; @(negedge clk); end
    total++;
    if (n != 20) begin bad++; $display("FAIL alert_len: buzzer cycles=%0d want 20", n); end
`else
    repeat (40) @(negedge clk);
    total++;
    if (buzzer !== 1'b1) begin bad++; $display("FAIL alert_hold: buz=%0d want 1", buzzer); end
    press(1, 0, 0);
`endif
    total++;
    if ({phase, running, remain_s, total_s, sess_cnt, buzzer} !==
        {2'd1, 1'b1, 16'd2, 16'd2, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL alert_exit: ph=%0d run=%0d rem=%0d tot=%0d sess=%0d buz=%0d want 1 1 2 2 1 0",
               phase, running, remain_s, total_s, sess_cnt, buzzer);
    end
  endtask

  task automatic test_long_break();
    fresh_run();
    finish_phase();
    finish_phase();
    total++;
    if ({phase, remain_s, sess_cnt} !== {2'd0, 16'd3, 3'd1}) begin
      bad++; $display("FAIL second_work: ph=%0d rem=%0d sess=%0d want 0 3 1", phase, remain_s, sess_cnt);
    end
    finish_phase();
    total++;
    if ({phase, total_s, remain_s, sess_cnt} !== {2'd2, 16'd4, 16'd4, 3'd0}) begin
      bad++;
      $display("FAIL long_break: ph=%0d tot=%0d rem=%0d sess=%0d want 2 4 4 0", phase, total_s, remain_s, sess_cnt);
    end
  endtask

  task automatic test_pause();
    fresh_run();
    repeat (10) @(negedge clk);
    press(1, 0, 0);
    repeat (50) @(negedge clk);
    total++;
    if (remain_s !== 16'd2 || running !== 1'b0) begin
      bad++; $display("FAIL paused: rem=%0d run=%0d want 2 0", remain_s, running);
    end
    press(1, 0, 0);
    repeat (7) @(negedge clk);
    total++;
    if (remain_s !== 16'd2 || running !== 1'b1) begin
      bad++; $display("FAIL resume_early: rem=%0d run=%0d want 2 1", remain_s, running);
    end
    @(negedge clk);
    total++;
    if (remain_s !== 16'd1) begin
      bad++; $display("FAIL resume_prescaler: rem=%0d want 1", remain_s);
    end
  endtask

  task automatic test_skip_and_clear();
    bit saw;
    do_reset();
    press(0, 1, 0);
    total++;
    if ({phase, running, remain_s, sess_cnt, phase_done} !== {2'd1, 1'b0, 16'd2, 3'd1, 1'b0}) begin
      bad++; $display("FAIL idle_skip: ph=%0d run=%0d rem=%0d sess=%0d done=%0d want 1 0 2 1 0",
                      phase, running, remain_s, sess_cnt, phase_done);
    end
    press(1, 0, 0);
    press(0, 1, 0);
    total++;
    if ({phase, running, remain_s, phase_done} !== {2'd0, 1'b1, 16'd3, 1'b1}) begin
      bad++; $display("FAIL run_skip: ph=%0d run=%0d rem=%0d done=%0d want 0 1 3 1",
                      phase, running, remain_s, phase_done);
    end
    btn_skip = 1; btn_clear = 1;
    @(negedge clk);
    btn_skip = 0; btn_clear = 0;
    saw = phase_done;
    @(negedge clk);
    saw = saw | phase_done;
    total++;
    if ({phase, running, remain_s, total_s, sess_cnt, saw} !== {2'd0, 1'b0, 16'd3, 16'd3, 3'd0, 1'b0}) begin
      bad++; $display("FAIL clear_wins: ph=%0d run=%0d rem=%0d tot=%0d sess=%0d done=%0d want 0 0 3 3 0 0",
                      phase, running, remain_s, total_s, sess_cnt, saw);
    end
  endtask

  task automatic test_async_reset();
    fresh_run();
    press(0, 1, 0);
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    total++;
    if ({phase, running, remain_s, total_s, sess_cnt, phase_done, buzzer} !==
        {2'd0, 1'b0, 16'd3, 16'd3, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: ph=%0d run=%0d rem=%0d tot=%0d sess=%0d done=%0d buz=%0d want 0 0 3 3 0 0 0",
               phase, running, remain_s, total_s, sess_cnt, phase_done, buzzer);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [40:0] got, exp;
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 3000 && errs < 5; i++) begin
      got = {phase, running, remain_s, total_s, sess_cnt, phase_done, buzzer};
      exp = {2'(m_phase), (m_mode == 1), 16'(m_remain), 16'(m_total), 3'(m_sess), m_done, (m_mode == 3)};
      total++;
      if (got !== exp) begin
        bad++; errs++;
        $display("FAIL random cycle %0d: got ph=%0d run=%0d rem=%0d tot=%0d sess=%0d done=%0d buz=%0d want ph=%0d run=%0d rem=%0d tot=%0d sess=%0d done=%0d buz=%0d",
                 i, got[40:39], got[38], got[37:22], got[21:6], got[5:3], got[2], got[1],
                 exp[40:39], exp[38], exp[37:22], exp[21:6], exp[5:3], exp[2], exp[1]);
      end
      if ($urandom_range(0, 29) == 0)  btn_start = ~btn_start;
      if ($urandom_range(0, 79) == 0)  btn_skip  = ~btn_skip;
      if ($urandom_range(0, 299) == 0) btn_clear = ~btn_clear;
      @(negedge clk);
    end
    btn_start = 0; btn_skip = 0; btn_clear = 0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_alert();
    test_long_break();
    test_pause();
    test_skip_and_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pomodoro_sequencer.md
Name: pomodoro_sequencer

Overview:
Session scheduler for the Pomodoro timer. Owns the one-second countdown and sequences WORK -> SHORT_BREAK phases, inserting LONG_BREAK after every LONG_EVERY work sessions. Decodes start/pause, skip and clear requests. Presents remaining/total seconds and the current phase to the BCD/7-segment display path, and drives a buzzer pulse at each phase end.

Parameters:
CLK_HZ, 125000000, clock frequency; the one-second tick period in cycles
WORK_S, 1500, work phase length in seconds
SHORT_S, 300, short break length in seconds
LONG_S, 900, long break length in seconds
LONG_EVERY, 4, completed work sessions per long break (>=1)
ALERT_S, 3, buzzer/alert duration in seconds (>=1)
TIME_W, 16, width of second counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_start  in  1  start/pause request; level, already debounced and synchronous; acted on at rising edge
btn_skip  in  1  skip current phase; rising edge
btn_clear  in  1  return to IDLE, clear session count; rising edge
phase  out  2  0=WORK, 1=SHORT_BREAK, 2=LONG_BREAK
running  out  1  high in RUN
remain_s  out  TIME_W  seconds left in current phase
total_s  out  TIME_W  length of current phase
sess_cnt  out  3  work sessions completed modulo LONG_EVERY
phase_done  out  1  one-cycle pulse when a phase completes or is skipped
buzzer  out  1  high throughout ALERT

Behaviour:
- Reset (async, rst_n=0): state=IDLE, phase=WORK, remain_s=total_s=WORK_S, sess_cnt=0, running=0, phase_done=0, buzzer=0, tick prescaler=0.
- Edge detect: registered previous level per button; an action fires on the cycle after a 0->1 transition. Priority per cycle: clear > skip > start.
- Tick: prescaler counts 0..CLK_HZ-1 only in RUN and ALERT; tick=1 when count==CLK_HZ-1, then wraps to 0. Prescaler is zeroed on entry to RUN from IDLE, on any phase change, and on clear. Pause freezes it; it is not zeroed.
- States:
  - IDLE: start -> RUN. skip -> advance phase, stay IDLE.
  - RUN: tick decrements remain_s. Tick with remain_s==1 -> remain_s=0, phase_done pulse, -> ALERT. start -> PAUSE. skip -> phase_done pulse, advance phase, stay RUN.
  - PAUSE: outputs frozen. start -> RUN. skip -> advance phase, -> IDLE.
  - ALERT: buzzer=1, alert counter counts ticks; see optional feature. start -> advance phase, -> RUN.
- clear in any state -> IDLE, phase=WORK, remain_s=total_s=WORK_S, sess_cnt=0.
- Advance phase:
  - From WORK: sess_cnt+1; if the new count == LONG_EVERY then sess_cnt=0 and phase=LONG_BREAK, else phase=SHORT_BREAK.
  - From either break: phase=WORK.
  - total_s and remain_s are loaded with the new phase length in the same cycle.
- A skipped WORK phase still counts as a session.
- Arithmetic: unsigned. remain_s never underflows; a tick at 0 outside RUN is ignored.
- Latency: button edge to state/output change is 2 cycles (sample + act). A tick updates remain_s on the following edge.

Optional Feature:
- Macro POMO_AUTO_ADVANCE_EN.
- Defined: ALERT exits automatically after ALERT_S ticks. It advances the phase, enters RUN and drops buzzer on the exit cycle. start still exits ALERT early.
- Undefined: ALERT holds buzzer until start. The alert counter saturates and is unused.

Decomposition:
- Package pomodoro_pkg: phase encoding constants (PH_WORK, PH_SHORT, PH_LONG); state encoding (ST_IDLE, ST_RUN, ST_PAUSE, ST_ALERT); function phase_len(phase) returning the TIME_W length.
- Sub-module pomo_tick_gen: CLK_HZ prescaler with enable and clear inputs and a tick output.

Test Plan:
All scenarios use CLK_HZ=10, WORK_S=3, SHORT_S=2, LONG_S=4, LONG_EVERY=2, ALERT_S=2.
1. Reset, then pulse start -> running=1. remain_s goes 3,2,1,0 at 10-cycle spacing. phase_done pulses once. buzzer=1, state ALERT.
2. Macro undefined, in ALERT: press start -> phase=SHORT_BREAK, remain_s=total_s=2, sess_cnt=1, buzzer=0, running=1.
3. Complete two WORK phases -> second WORK end leads to phase=LONG_BREAK, total_s=4, sess_cnt=0.
4. In RUN at remain_s=2, press start, hold 50 cycles, press start -> remain_s stays 2 while paused. Decrement resumes with the prescaler continuing from its frozen count.
5. In RUN, press skip and clear in the same cycle -> clear wins: IDLE, WORK, remain_s=3, sess_cnt=0, no phase_done.
6. Macro defined: let WORK expire -> buzzer high exactly 20 cycles, then auto RUN in SHORT_BREAK with remain_s=2. Drop rst_n mid-RUN -> all outputs return to reset values immediately.
